// File: rtl/tlb_lock_arbiter_pkg.sv
// Shared types and constants for the TLB lookup-port lock arbiter.
package tlb_lock_arbiter_pkg;

  localparam int unsigned VADDR_BITS      = 48;
  localparam int unsigned PID_BITS        = 6;
  localparam int unsigned N_TLB_ARB_PORTS = 2;

  typedef enum logic {ST_IDLE, ST_HELD} tlb_arb_state_t;

  function automatic int unsigned arb_id_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tlb_lock_arbiter_if.sv
// Requester-side lock handshake plus the muxed TLB lookup channel.
interface tlb_lock_arbiter_if #(
  parameter int unsigned N_PORTS = tlb_lock_arbiter_pkg::N_TLB_ARB_PORTS,
  parameter int unsigned ID_BITS = tlb_lock_arbiter_pkg::arb_id_bits(N_PORTS)
);
  localparam int unsigned VB = tlb_lock_arbiter_pkg::VADDR_BITS;
  localparam int unsigned PB = tlb_lock_arbiter_pkg::PID_BITS;

  logic [N_PORTS-1:0]    lock;
  logic [N_PORTS-1:0]    unlock;
  logic [N_PORTS-1:0]    grant;
  logic [ID_BITS-1:0]    owner_id;
  logic                  busy;
  logic [N_PORTS*VB-1:0] s_addr;
  logic [N_PORTS*PB-1:0] s_pid;
  logic [N_PORTS-1:0]    s_strm;
  logic [N_PORTS-1:0]    s_wr;
  logic [N_PORTS-1:0]    s_valid;
  logic [VB-1:0]         m_addr;
  logic [PB-1:0]         m_pid;
  logic                  m_strm;
  logic                  m_wr;
  logic                  m_valid;
  logic                  timeout_irq;

  modport slave (
    input  lock, unlock, s_addr, s_pid, s_strm, s_wr, s_valid,
    output grant, owner_id, busy, m_addr, m_pid, m_strm, m_wr, m_valid, timeout_irq
  );

  modport master (
    output lock, unlock, s_addr, s_pid, s_strm, s_wr, s_valid,
    input  grant, owner_id, busy, m_addr, m_pid, m_strm, m_wr, m_valid, timeout_irq
  );

endinterface

// File: rtl/tlb_lock_arbiter_pick.sv
// Combinational winner pick: round-robin from rr_ptr with wrap, or lowest index.
module tlb_arb_pick
  import tlb_lock_arbiter_pkg::*;
#(
  parameter int unsigned N_PORTS = N_TLB_ARB_PORTS,
  parameter bit          RR_EN   = 1'b1,
  parameter int unsigned ID_BITS = arb_id_bits(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [ID_BITS-1:0] rr_ptr,
  input  logic [N_PORTS-1:0] excl,
  output logic [ID_BITS-1:0] winner,
  output logic               found
);

  localparam logic [ID_BITS:0] NP = (ID_BITS + 1)'(N_PORTS);

  logic [N_PORTS-1:0] cand;

  assign cand = req & ~excl;

  always_comb begin : pick
    logic [ID_BITS:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      idx = (ID_BITS + 1)'(i);
      // One extra bit keeps rr_ptr+i exact so the wrap works for non-power-of-two N.
      if (RR_EN) begin
        idx = idx + {1'b0, rr_ptr};
        if (idx >= NP) idx = idx - NP;
      end
      if (!found && cand[idx[ID_BITS-1:0]]) begin
        winner = idx[ID_BITS-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlb_lock_arbiter.sv
// Exclusive-ownership arbiter for a shared TLB lookup port with same-edge
// handover, round-robin/fixed-priority pick and a hold-timeout watchdog.
module tlb_lock_arbiter
  import tlb_lock_arbiter_pkg::*;
#(
  parameter int unsigned N_PORTS  = N_TLB_ARB_PORTS,
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned MAX_HOLD = 1024,
  parameter int unsigned ID_BITS  = arb_id_bits(N_PORTS)
) (
  input  logic               aclk,
  input  logic               aresetn,
  tlb_lock_arbiter_if.slave  arb
);

  localparam int unsigned      HC_BITS  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_BITS-1:0] HOLD_MAX = HC_BITS'(MAX_HOLD);
  localparam logic [ID_BITS:0]   NP       = (ID_BITS + 1)'(N_PORTS);

  tlb_arb_state_t     state_q, state_d;
  logic [N_PORTS-1:0] grant_q, grant_d;
  logic [ID_BITS-1:0] owner_q, owner_d;
  logic [ID_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [HC_BITS-1:0] hold_cnt_q, hold_cnt_d;
  logic               irq_q, irq_d;

  logic [N_PORTS-1:0] excl;
  logic [ID_BITS-1:0] winner;
  logic               found;
  logic               owner_rel;
  logic               take;
  logic [ID_BITS:0]   win_inc;
  logic [ID_BITS-1:0] next_ptr;

  // While held, only an owner release opens a pick, and the releasing port sits it out.
  assign owner_rel = (state_q == ST_HELD) && (|(arb.unlock & grant_q));
  assign excl      = (state_q == ST_HELD) ? grant_q : '0;

  tlb_arb_pick #(
    .N_PORTS (N_PORTS),
    .RR_EN   (RR_EN),
    .ID_BITS (ID_BITS)
  ) u_pick (
    .req    (arb.lock),
    .rr_ptr (rr_ptr_q),
    .excl   (excl),
    .winner (winner),
    .found  (found)
  );

  assign win_inc  = {1'b0, winner} + (ID_BITS + 1)'(1);
  assign next_ptr = (win_inc == NP) ? '0 : win_inc[ID_BITS-1:0];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    irq_d      = 1'b0;
    take       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        take = found;
      end
      ST_HELD: begin
        if (owner_rel) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            owner_d    = '0;
            hold_cnt_d = '0;
          end
        end else if ((MAX_HOLD != 0) && (hold_cnt_q != HOLD_MAX)) begin
          hold_cnt_d = hold_cnt_q + HC_BITS'(1);
          irq_d      = (hold_cnt_d == HOLD_MAX);
        end
      end
    endcase

    if (take) begin
      state_d         = ST_HELD;
      grant_d         = '0;
      grant_d[winner] = 1'b1;
      owner_d         = winner;
      rr_ptr_d        = next_ptr;
      hold_cnt_d      = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      irq_q      <= irq_d;
    end
  end

  logic [VADDR_BITS-1:0] m_addr;
  logic [PID_BITS-1:0]   m_pid;
  logic                  m_strm;
  logic                  m_wr;
  logic                  sel_valid;

  // owner_q returns to 0 when idle, so the idle mux naturally shows port 0.
  always_comb begin
    m_addr    = arb.s_addr[VADDR_BITS-1:0];
    m_pid     = arb.s_pid[PID_BITS-1:0];
    m_strm    = arb.s_strm[0];
    m_wr      = arb.s_wr[0];
    sel_valid = arb.s_valid[0];
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (owner_q == ID_BITS'(i)) begin
        m_addr    = arb.s_addr[i*VADDR_BITS +: VADDR_BITS];
        m_pid     = arb.s_pid[i*PID_BITS +: PID_BITS];
        m_strm    = arb.s_strm[i];
        m_wr      = arb.s_wr[i];
        sel_valid = arb.s_valid[i];
      end
    end
  end

  assign arb.grant       = grant_q;
  assign arb.owner_id    = owner_q;
  assign arb.busy        = (state_q == ST_HELD);
  assign arb.timeout_irq = irq_q;
  assign arb.m_addr      = m_addr;
  assign arb.m_pid       = m_pid;
  assign arb.m_strm      = m_strm;
  assign arb.m_wr        = m_wr;
  assign arb.m_valid     = sel_valid & (state_q == ST_HELD);

endmodule

// File: tb/tb_tlb_lock_arbiter.sv
// Directed bench: a round-robin instance (MAX_HOLD=8) and a fixed-priority
// instance (watchdog off) driven by the same stimulus.
module tb_tlb_lock_arbiter;
  import tlb_lock_arbiter_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned IB = 2;

  logic                   aclk = 1'b0;
  logic                   aresetn;
  logic [NP-1:0]          lock, unlock, s_strm, s_wr, s_valid;
  logic [NP*VADDR_BITS-1:0] s_addr;
  logic [NP*PID_BITS-1:0]   s_pid;

  int ntests = 0;
  int nfail  = 0;
  int order [4] = '{0, 1, 3, 0};

  always #5 aclk = ~aclk;

  tlb_lock_arbiter_if #(.N_PORTS(NP), .ID_BITS(IB)) if_rr ();
  tlb_lock_arbiter_if #(.N_PORTS(NP), .ID_BITS(IB)) if_fp ();

  assign if_rr.lock = lock;     assign if_fp.lock = lock;
  assign if_rr.unlock = unlock; assign if_fp.unlock = unlock;
  assign if_rr.s_addr = s_addr; assign if_fp.s_addr = s_addr;
  assign if_rr.s_pid = s_pid;   assign if_fp.s_pid = s_pid;
  assign if_rr.s_strm = s_strm; assign if_fp.s_strm = s_strm;
  assign if_rr.s_wr = s_wr;     assign if_fp.s_wr = s_wr;
  assign if_rr.s_valid = s_valid; assign if_fp.s_valid = s_valid;

  tlb_lock_arbiter #(.N_PORTS(NP), .RR_EN(1'b1), .MAX_HOLD(8), .ID_BITS(IB)) u_rr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .arb     (if_rr.slave)
  );

  tlb_lock_arbiter #(.N_PORTS(NP), .RR_EN(1'b0), .MAX_HOLD(0), .ID_BITS(IB)) u_fp (
    .aclk    (aclk),
    .aresetn (aresetn),
    .arb     (if_fp.slave)
  );

  function automatic logic [VADDR_BITS-1:0] addr_of(input int i);
    return 48'h0000_CAFE_0000 + VADDR_BITS'(i) * 48'h1000;
  endfunction

  function automatic logic [PID_BITS-1:0] pid_of(input int i);
    return PID_BITS'(i + 5);
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    lock    = '0;
    unlock  = '0;
    s_valid = 4'b1111;
    s_strm  = 4'b0011;
    s_wr    = 4'b0101;
    s_addr  = '0;
    s_pid   = '0;
    for (int i = 0; i < NP; i++) begin
      s_addr[i*VADDR_BITS +: VADDR_BITS] = addr_of(i);
      s_pid[i*PID_BITS +: PID_BITS]      = pid_of(i);
    end
    tick(); tick();
    chk("rst_grant", if_rr.grant, 0);
    chk("rst_busy", if_rr.busy, 0);
    chk("rst_owner", if_rr.owner_id, 0);
    chk("rst_irq", if_rr.timeout_irq, 0);
    chk("rst_mvalid", if_rr.m_valid, 0);
    chk("rst_fp_grant", if_fp.grant, 0);
    aresetn = 1'b1;

    // single requester
    lock = 4'b0100;
    tick();
    chk("single_grant", if_rr.grant, 4'b0100);
    chk("single_owner", if_rr.owner_id, 2);
    chk("single_busy", if_rr.busy, 1);
    chk("single_maddr", if_rr.m_addr, addr_of(2));
    chk("single_mpid", if_rr.m_pid, pid_of(2));
    chk("single_mwr", if_rr.m_wr, 1);
    chk("single_mstrm", if_rr.m_strm, 0);
    chk("single_mvalid", if_rr.m_valid, 1);
    s_addr[2*VADDR_BITS +: VADDR_BITS] = 48'h0000_BEEF_1234;
    s_valid[2] = 1'b0;
    #1;
    chk("single_maddr_follow", if_rr.m_addr, 48'h0000_BEEF_1234);
    chk("single_mvalid_follow", if_rr.m_valid, 0);
    s_addr[2*VADDR_BITS +: VADDR_BITS] = addr_of(2);
    s_valid[2] = 1'b1;
    repeat (4) tick();
    chk("single_hold", if_rr.grant, 4'b0100);
    lock = '0;
    unlock = 4'b0100;
    tick();
    unlock = '0;
    chk("single_rel_grant", if_rr.grant, 0);
    chk("single_rel_busy", if_rr.busy, 0);
    chk("single_rel_mvalid", if_rr.m_valid, 0);

    // round-robin contention from a freshly reset pointer
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    lock = 4'b1011;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("rr_order", if_rr.grant, 64'd1 << order[k]);
      chk("rr_no_gap", if_rr.busy, 1);
      tick(); tick();
      chk("rr_hold", if_rr.grant, 64'd1 << order[k]);
      if (k < 3) begin
        unlock = 4'b0001 << order[k];
        tick();
        unlock = '0;
      end
    end
    lock = '0;
    unlock = 4'b0001;
    tick();
    unlock = '0;
    chk("rr_idle", if_rr.busy, 0);

    // fixed priority vs round-robin
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    lock = 4'b1010;
    tick();
    chk("fp_first", if_fp.grant, 4'b0010);
    chk("fp_rr_first", if_rr.grant, 4'b0010);
    unlock = 4'b0010;
    tick();
    unlock = '0;
    chk("fp_excl_handover", if_fp.grant, 4'b1000);
    unlock = 4'b1000;
    tick();
    unlock = '0;
    chk("fp_back_to_1", if_fp.grant, 4'b0010);
    lock = 4'b1011;
    unlock = 4'b0010;
    tick();
    unlock = '0;
    chk("fp_lowest", if_fp.grant, 4'b0001);
    chk("rr_from_ptr", if_rr.grant, 4'b1000);
    lock = 4'b1010;
    unlock = 4'b0001;
    tick();
    unlock = '0;
    chk("fp_port1_wins", if_fp.grant, 4'b0010);
    lock = 4'b1000;
    unlock = 4'b0010;
    tick();
    unlock = '0;
    chk("fp_port3_after_drop", if_fp.grant, 4'b1000);

    // ignored events
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    lock = 4'b0010;
    tick();
    chk("ign_grant", if_rr.grant, 4'b0010);
    lock = 4'b0011;
    unlock = 4'b0001;
    tick();
    unlock = '0;
    chk("ign_nonowner_unlock", if_rr.grant, 4'b0010);
    tick();
    chk("ign_lock_while_held", if_rr.grant, 4'b0010);
    lock = 4'b0010;
    unlock = 4'b0010;
    tick();
    unlock = '0;
    chk("self_rel_busy", if_rr.busy, 0);
    chk("self_rel_grant", if_rr.grant, 0);
    tick();
    chk("self_regrant", if_rr.grant, 4'b0010);
    chk("self_regrant_owner", if_rr.owner_id, 1);

    // watchdog
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk("wd_irq1", if_rr.timeout_irq, (c == 8) ? 64'd1 : 64'd0);
    end
    chk("wd_retain", if_rr.grant, 4'b0010);
    lock = 4'b0011;
    unlock = 4'b0010;
    tick();
    unlock = '0;
    chk("wd_handover", if_rr.grant, 4'b0001);
    chk("wd_handover_irq", if_rr.timeout_irq, 0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("wd_irq2", if_rr.timeout_irq, (c == 8) ? 64'd1 : 64'd0);
    end

    // reset mid-hold
    unlock = 4'b0001;
    tick();
    unlock = '0;
    chk("mid_owner1", if_rr.grant, 4'b0010);
    aresetn = 1'b0;
    lock = 4'b0011;
    tick();
    aresetn = 1'b1;
    chk("mid_rst_grant", if_rr.grant, 0);
    chk("mid_rst_busy", if_rr.busy, 0);
    chk("mid_rst_mvalid", if_rr.m_valid, 0);
    chk("mid_rst_owner", if_rr.owner_id, 0);
    tick();
    chk("mid_rst_regrant", if_rr.grant, 4'b0001);
    chk("fp_no_irq", if_fp.timeout_irq, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
